uno_var_gen: RTL and testbench
==============================

Name: uno_var_gen

Overview:
- Multi-lane, pipelined generator of the normalised variable fed to the unary (div/exp/log) evaluation datapath of the RAVEN PE array.
- Successor of the single-lane generator; adds:
  - NUM_LANE parallel lanes
  - valid/ready elastic handshake
  - signed normalisation (left and right shift)
  - shift/integer side outputs for later denormalisation
  - invalid-operand flagging
- Sits between the operand buffer and the polynomial/MAC stage.

Parameters:
- NUM_LANE, 4, number of independent lanes sharing one handshake and mode.
- INT_BW, 5, integer bits of the signed fixed-point operand.
- FRA_BW, 10, fraction bits.
- MUL_BW, 16, operand width; must equal 1+INT_BW+FRA_BW (elaboration error otherwise).
- SHIFT_BW, $clog2(MUL_BW)+1, derived localparam; width of the signed shift output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat this cycle.
- gemm_uno_i  in  2  mode: 00 gemm, 01 div, 10 exp, 11 log.
- x_i  in  NUM_LANE*MUL_BW  signed operands, lane k at [k*MUL_BW +: MUL_BW].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- mode_o  out  2  mode carried with the beat.
- var_o  out  NUM_LANE*MUL_BW  signed variable per lane.
- shift_o  out  NUM_LANE*SHIFT_BW  signed normalisation shift per lane.
- xint_o  out  NUM_LANE*(INT_BW+1)  signed integer part per lane (exp only).
- err_o  out  NUM_LANE  invalid operand per lane.

Behaviour:
- Clocking and reset:
  - Single clock clk; asynchronous active-low reset rst_n.
  - All registered outputs reset to 0, out_valid=0.
  - in_ready=1 one cycle after reset release, since it is combinational from s1_valid=0.
  - Reset mid-operation discards in-flight beats with no output.
- Pipeline:
  - Two stages, latency exactly 2 cycles from accepted beat to out_valid with no stalls.
  - Throughput 1 beat/cycle.
  - S1 registers x, mode and per-lane leading-one position p.
  - S2 registers the normalised results.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - s2_adv = s2_valid==0 || out_ready.
  - s1_adv = s1_valid==0 || s2_adv.
  - in_ready = s1_adv.
  - Output payload held stable while out_valid && !out_ready.
  - No beat dropped or duplicated.
  - Simultaneous accept and drain in a full pipe is allowed.
- Per lane, x treated as signed; POINT = 0.75 = 3<<(FRA_BW-2).
- div/log (01/11):
  - If x<=0: err=1, var=0, shift=0.
  - Else p = index of the most significant 1.
  - shift = (FRA_BW-1)-p.
  - If shift>=0: norm = x<<shift; else norm = x>>(-shift), truncating.
  - norm lies in [0.5,1); var = POINT - norm, a signed result in (-0.25,0.25].
  - xint=0.
- exp (10):
  - xint = x[MUL_BW-1:FRA_BW] (floor integer, signed).
  - var = zero-extended x[FRA_BW-1:0], i.e. the fraction in [0,1).
  - shift=0, err=0.
- gemm (00): var=0, shift=0, xint=0, err=0; the beat still flows so the handshake stays uniform.
- Lanes are fully independent except for the shared mode and handshake.

Optional Feature:
- Macro UNO_VAR_GEN_RND_EN.
- Defined: the right-shift path (shift<0) rounds half-up: norm = (x + (1<<(-shift-1))) >> (-shift).
  - If rounding yields norm=1.0, it is kept; var = POINT - 1.0 = -0.25.
- Undefined: truncation. Latency and interface are unchanged either way.

Decomposition:
- Package raven_uno_pkg holds:
  - uno_mode_e enum (UNO_GEMM, UNO_DIV, UNO_EXP, UNO_LOG).
  - POINT constant function of FRA_BW.
  - SHIFT_BW helper function.
- Sub-module lead_one_det:
  - Parametric MUL_BW priority encoder.
  - Outputs p and a zero flag.
  - Generic replacement for the fixed 16-bit encoder.
  - Instantiated NUM_LANE times.

Test Plan (default parameters):
- div, x=0x0400 (1.0) -> after 2 cycles: shift=-1, var=0x0100 (0.25), err=0.
- log, x=0x0100 (0.25) -> shift=+1, var=0x0100; log with x=0x0000 and with x=0xFC00 (-1.0) -> err=1, var=0, shift=0.
- exp, x=0x0A00 (2.5) -> xint=2, var=0x0200; exp with x=0xFA00 (-1.5) -> xint=-2, var=0x0200.
- div, x=0x0401 -> var=0x0100 without UNO_VAR_GEN_RND_EN, var=0x00FF with it.
- Backpressure:
  - Stream 8 beats with out_ready low for cycles 3-6.
  - Required: in_ready falls once both stages are full, output payload is stable while stalled, all 8 beats arrive in order with none lost or duplicated.
- Assert rst_n low while 2 beats are in flight -> out_valid=0 immediately, all outputs 0, no stale beat after release.

Source files
------------

// File: rtl/raven_uno_pkg.sv
// Shared types and helpers for the RAVEN unary-variable generator.
//   uno_mode_e   : beat mode (gemm / div / exp / log)
//   uno_point    : 0.75 in the fixed-point format with fra_bw fraction bits
//   uno_shift_bw : width of the signed normalisation shift for a mul_bw operand
package raven_uno_pkg;

  typedef enum logic [1:0] {
    UNO_GEMM = 2'b00,
    UNO_DIV  = 2'b01,
    UNO_EXP  = 2'b10,
    UNO_LOG  = 2'b11
  } uno_mode_e;

  function automatic int unsigned uno_point(input int unsigned fra_bw);
    return 32'd3 << (fra_bw - 32'd2);
  endfunction

  function automatic int unsigned uno_shift_bw(input int unsigned mul_bw);
    return $clog2(mul_bw) + 32'd1;
  endfunction

endpackage

// File: rtl/lead_one_det.sv
// Parametric priority encoder: position of the most significant set bit.
//   x    : operand
//   p    : index of the highest 1 (0 when x is zero)
//   zero : x has no set bit
module lead_one_det #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]         x,
  output logic [$clog2(W)-1:0] p,
  output logic                 zero
);

  localparam int unsigned PW = $clog2(W);

  // Later (higher) indices overwrite earlier ones, so the MSB wins.
  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) p = PW'(i);
    end
  end

  assign zero = ~|x;

endmodule

// File: rtl/uno_var_gen.sv
// Multi-lane two-stage generator of the normalised variable for the unary
// (div/exp/log) datapath, with a valid/ready elastic handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input beat handshake (in_ready is combinational)
//   gemm_uno_i           : mode 00 gemm, 01 div, 10 exp, 11 log
//   x_i                  : signed operands, lane k at [k*MUL_BW +: MUL_BW]
//   out_valid / out_ready: output beat handshake
//   mode_o, var_o, shift_o, xint_o, err_o : per-beat / per-lane results
// Build option: define UNO_VAR_GEN_RND_EN to round half-up on the
// right-shift normalisation path instead of truncating.
module uno_var_gen
  import raven_uno_pkg::*;
#(
  parameter  int unsigned NUM_LANE = 4,
  parameter  int unsigned INT_BW   = 5,
  parameter  int unsigned FRA_BW   = 10,
  parameter  int unsigned MUL_BW   = 16,
  localparam int unsigned SHIFT_BW = uno_shift_bw(MUL_BW)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     gemm_uno_i,
  input  logic [NUM_LANE*MUL_BW-1:0]     x_i,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [1:0]                     mode_o,
  output logic [NUM_LANE*MUL_BW-1:0]     var_o,
  output logic [NUM_LANE*SHIFT_BW-1:0]   shift_o,
  output logic [NUM_LANE*(INT_BW+1)-1:0] xint_o,
  output logic [NUM_LANE-1:0]            err_o
);

  localparam int unsigned PW = $clog2(MUL_BW);
  localparam int unsigned XB = INT_BW + 1;
  localparam int unsigned SW = MUL_BW + 1;
  localparam logic [MUL_BW-1:0] POINT = MUL_BW'(uno_point(FRA_BW));

  if (MUL_BW != 1 + INT_BW + FRA_BW) begin : g_bw_chk
    $error("uno_var_gen: MUL_BW must equal 1+INT_BW+FRA_BW");
  end

  logic s1_valid, s2_valid, s1_adv, s2_adv;
  uno_mode_e s1_mode, s2_mode;
  logic [NUM_LANE-1:0][MUL_BW-1:0]   s1_x;
  logic [NUM_LANE-1:0][PW-1:0]       s1_p, lod_p;
  logic [NUM_LANE-1:0]               s1_zero, lod_zero;
  logic [NUM_LANE-1:0][MUL_BW-1:0]   var_d, s2_var;
  logic [NUM_LANE-1:0][SHIFT_BW-1:0] shift_d, s2_shift;
  logic [NUM_LANE-1:0][XB-1:0]       xint_d, s2_xint;
  logic [NUM_LANE-1:0]               err_d, s2_err;

  // Elastic handshake: a stage advances when empty or when its successor does.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    logic [SHIFT_BW-1:0] sh, ramt;
    logic [MUL_BW-1:0]   norm;
    logic [MUL_BW-1:0]   l_var;
    logic [SHIFT_BW-1:0] l_shift;
    logic [XB-1:0]       l_xint;
    logic                l_err;
`ifdef UNO_VAR_GEN_RND_EN
    logic [SW-1:0]       rnd_sum;
`endif

    lead_one_det #(.W(MUL_BW)) u_lod (
      .x    (x_i[k*MUL_BW +: MUL_BW]),
      .p    (lod_p[k]),
      .zero (lod_zero[k])
    );

    // Bring the leading one to bit FRA_BW-1 so norm lands in [0.5,1).
    always_comb begin
      l_var   = '0;
      l_shift = '0;
      l_xint  = '0;
      l_err   = 1'b0;
      sh      = SHIFT_BW'(FRA_BW - 1) - SHIFT_BW'(s1_p[k]);
      ramt    = -sh;
`ifdef UNO_VAR_GEN_RND_EN
      rnd_sum = {1'b0, s1_x[k]} + (SW'(1) << (ramt - SHIFT_BW'(1)));
      norm    = sh[SHIFT_BW-1] ? MUL_BW'(rnd_sum >> ramt) : (s1_x[k] << sh);
`else
      norm    = sh[SHIFT_BW-1] ? (s1_x[k] >> ramt) : (s1_x[k] << sh);
`endif
      case (s1_mode)
        UNO_DIV, UNO_LOG: begin
          if (s1_zero[k] || s1_x[k][MUL_BW-1]) begin
            l_err = 1'b1;
          end else begin
            l_var   = POINT - norm;
            l_shift = sh;
          end
        end
        UNO_EXP: begin
          l_xint = XB'(s1_x[k][MUL_BW-1:FRA_BW]);
          l_var  = MUL_BW'(s1_x[k][FRA_BW-1:0]);
        end
        default: ;
      endcase
    end

    assign var_d[k]   = l_var;
    assign shift_d[k] = l_shift;
    assign xint_d[k]  = l_xint;
    assign err_d[k]   = l_err;
  end

  // Stage 1: operands, mode and leading-one positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= UNO_GEMM;
      s1_x     <= '0;
      s1_p     <= '0;
      s1_zero  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= uno_mode_e'(gemm_uno_i);
        s1_x    <= x_i;
        s1_p    <= lod_p;
        s1_zero <= lod_zero;
      end
    end
  end

  // Stage 2: normalised results, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= UNO_GEMM;
      s2_var   <= '0;
      s2_shift <= '0;
      s2_xint  <= '0;
      s2_err   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mode  <= s1_mode;
        s2_var   <= var_d;
        s2_shift <= shift_d;
        s2_xint  <= xint_d;
        s2_err   <= err_d;
      end
    end
  end

  assign out_valid = s2_valid;
  assign mode_o    = s2_mode;
  assign var_o     = s2_var;
  assign shift_o   = s2_shift;
  assign xint_o    = s2_xint;
  assign err_o     = s2_err;

endmodule

// File: tb/tb_uno_var_gen.sv
// Self-checking bench for uno_var_gen (default parameters): directed vector
// table, backpressure and reset sequences, and a randomized stream checked
// by an arithmetic reference model through an in-order scoreboard.
module tb_uno_var_gen;

  localparam int FRA = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  gemm_uno_i;
  logic [63:0] x_i;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  mode_o;
  logic [63:0] var_o;
  logic [19:0] shift_o;
  logic [23:0] xint_o;
  logic [3:0]  err_o;

  uno_var_gen dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .gemm_uno_i(gemm_uno_i), .x_i(x_i), .out_valid(out_valid),
    .out_ready(out_ready), .mode_o(mode_o), .var_o(var_o),
    .shift_o(shift_o), .xint_o(xint_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic [63:0] vr;
    logic [19:0] sh;
    logic [23:0] xi;
    logic [3:0]  er;
  } beat_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] x;
    logic [15:0] vr;
    logic [4:0]  sh;
    logic [5:0]  xi;
    logic        er;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_rx     = 0;
  beat_t sb[$];
  logic  stall_prev = 1'b0;
  beat_t held;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: find the binade of x, scale to [0.5,1) with integer arithmetic.
  function automatic beat_t model(input logic [1:0] m, input logic [63:0] x);
    beat_t b;
    b = '0;
    b.mode = m;
    for (int k = 0; k < 4; k++) begin
      int xs, p, s, norm, d, frac;
      xs = int'($signed(x[k*16 +: 16]));
      case (m)
        2'b01, 2'b11: begin
          if (xs <= 0) begin
            b.er[k] = 1'b1;
          end else begin
            p = 0;
            while ((xs >> (p + 1)) != 0) p++;
            s = FRA - 1 - p;
            if (s >= 0) norm = xs * (1 << s);
            else begin
              d = 1 << (-s);
`ifdef UNO_VAR_GEN_RND_EN
              norm = (xs + d / 2) / d;
`else
              norm = xs / d;
`endif
            end
            b.vr[k*16 +: 16] = 16'((3 * (1 << FRA)) / 4 - norm);
            b.sh[k*5 +: 5]   = 5'(s);
          end
        end
        2'b10: begin
          frac = xs & ((1 << FRA) - 1);
          b.vr[k*16 +: 16] = 16'(frac);
          b.xi[k*6 +: 6]   = 6'((xs - frac) / (1 << FRA));
        end
        default: ;
      endcase
    end
    return b;
  endfunction

  function automatic logic [63:0] rand_x();
    logic [63:0] v;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 7))
        0: v[k*16 +: 16] = 16'h0000;
        1: v[k*16 +: 16] = 16'h7FFF - 16'($urandom_range(0, 40));
        2: v[k*16 +: 16] = 16'($urandom_range(1, 64));
        default: v[k*16 +: 16] = 16'($urandom());
      endcase
    end
    return v;
  endfunction

  // Monitor: values here are what the next rising edge will act on.
  always @(negedge clk) begin
    beat_t cur, e;
    if (!rst_n) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      cur = {mode_o, var_o, shift_o, xint_o, err_o};
      if (stall_prev) begin
        check("hold_valid", 128'(out_valid), 128'(1'b1));
        check("hold_payload", 128'(cur), 128'(held));
      end
      if (out_valid && out_ready) begin
        n_rx++;
        if (sb.size() == 0) begin
          check("spurious_beat", 128'(out_valid), 128'(1'b0));
        end else begin
          e = sb.pop_front();
          check("sb_mode",  128'(mode_o),  128'(e.mode));
          check("sb_var",   128'(var_o),   128'(e.vr));
          check("sb_shift", 128'(shift_o), 128'(e.sh));
          check("sb_xint",  128'(xint_o),  128'(e.xi));
          check("sb_err",   128'(err_o),   128'(e.er));
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = cur;
      if (in_valid && in_ready) sb.push_back(model(gemm_uno_i, x_i));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check(name, 128'(sb.size()), 128'(0));
  endtask

  vec_t        tbl[11];
  logic [15:0] bp_x[8];
  logic [1:0]  bp_m[8];
  logic        acc, saw_low;
  int          cyc, idx, rx0, n_seen;

  initial begin
    tbl[0]  = '{2'b01, 16'h0400, 16'h0100, 5'h1F, 6'h00, 1'b0};
    tbl[1]  = '{2'b11, 16'h0100, 16'h0100, 5'h01, 6'h00, 1'b0};
    tbl[2]  = '{2'b11, 16'h0000, 16'h0000, 5'h00, 6'h00, 1'b1};
    tbl[3]  = '{2'b11, 16'hFC00, 16'h0000, 5'h00, 6'h00, 1'b1};
    tbl[4]  = '{2'b10, 16'h0A00, 16'h0200, 5'h00, 6'h02, 1'b0};
    tbl[5]  = '{2'b10, 16'hFA00, 16'h0200, 5'h00, 6'h3E, 1'b0};
`ifdef UNO_VAR_GEN_RND_EN
    tbl[6]  = '{2'b01, 16'h0401, 16'h00FF, 5'h1F, 6'h00, 1'b0};
    tbl[7]  = '{2'b01, 16'h7FFF, 16'hFF00, 5'h1B, 6'h00, 1'b0};
`else
    tbl[6]  = '{2'b01, 16'h0401, 16'h0100, 5'h1F, 6'h00, 1'b0};
    tbl[7]  = '{2'b01, 16'h7FFF, 16'hFF01, 5'h1B, 6'h00, 1'b0};
`endif
    tbl[8]  = '{2'b00, 16'h1234, 16'h0000, 5'h00, 6'h00, 1'b0};
    tbl[9]  = '{2'b01, 16'h0001, 16'h0100, 5'h09, 6'h00, 1'b0};
    tbl[10] = '{2'b01, 16'h8000, 16'h0000, 5'h00, 6'h00, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; gemm_uno_i = 2'b00; x_i = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_payload", 128'({mode_o, var_o, shift_o, xint_o, err_o}), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 128'(in_ready), 128'(1));

    // Directed vectors with exact two-cycle latency.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; gemm_uno_i = tbl[i].mode; x_i = {4{tbl[i].x}};
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("lat_not_early", 128'(out_valid), 128'(0));
      @(posedge clk); @(negedge clk);
      check("lat_valid", 128'(out_valid), 128'(1));
      check("vec_mode",  128'(mode_o),  128'(tbl[i].mode));
      check("vec_var",   128'(var_o),   128'({4{tbl[i].vr}}));
      check("vec_shift", 128'(shift_o), 128'({4{tbl[i].sh}}));
      check("vec_xint",  128'(xint_o),  128'({4{tbl[i].xi}}));
      check("vec_err",   128'(err_o),   128'({4{tbl[i].er}}));
      @(posedge clk); #1;
    end

    // Backpressure: 8 beats, consumer stalled for cycles 3-6.
    for (int i = 0; i < 8; i++) begin
      bp_x[i] = 16'($urandom_range(1, 16'h7FFF));
      bp_m[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
    end
    rx0 = n_rx; cyc = 0; idx = 0; saw_low = 1'b0;
    in_valid = 1'b1; gemm_uno_i = bp_m[0]; x_i = {bp_x[0], bp_x[0] ^ 16'h00FF, 16'h0400, bp_x[0] >> 3};
    while (idx < 8 && cyc < 100) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!in_ready) saw_low = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (idx < 8) begin
        gemm_uno_i = bp_m[idx];
        x_i = {bp_x[idx], bp_x[idx] ^ 16'h00FF, 16'h0400, bp_x[idx] >> 3};
      end else in_valid = 1'b0;
      out_ready = !(cyc >= 3 && cyc <= 6);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_all_sent", 128'(idx), 128'(8));
    check("bp_in_ready_fell", 128'(saw_low), 128'(1));
    drain("bp_drain");
    check("bp_rx_count", 128'(n_rx - rx0), 128'(8));

    // Reset with two beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; gemm_uno_i = 2'b01; x_i = {4{16'h0400}};
    @(posedge clk); #1 x_i = {4{16'h0A00}}; gemm_uno_i = 2'b10;
    @(posedge clk); #1 in_valid = 1'b0;
    check("inflight_valid", 128'(out_valid), 128'(1));
    rst_n = 1'b0; #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_payload", 128'({mode_o, var_o, shift_o, xint_o, err_o}), 128'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) n_seen++;
    end
    check("no_stale_beat", 128'(n_seen), 128'(0));
    check("in_ready_post_rst", 128'(in_ready), 128'(1));

    // Randomized stream with random stalls on both sides.
    @(posedge clk); #1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        if ($urandom_range(0, 9) < 7) begin
          in_valid = 1'b1;
          gemm_uno_i = 2'($urandom_range(0, 3));
          x_i = rand_x();
        end else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 9) < 7);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
